// File: rtl/stream_max_min.sv
// rtl/stream_max_min.sv - streaming frame max/min/argmax with registered valid/ready result port
module stream_max_min #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 3,
  parameter int IDX_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_max,
  output logic [WIDTH-1:0] o_out_min,
  output logic [IDX_W-1:0] o_out_max_idx
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_count;
  logic [WIDTH-1:0] r_run_max;
  logic [WIDTH-1:0] r_run_min;
  logic [IDX_W-1:0] r_run_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_max;
  logic [WIDTH-1:0] r_out_min;
  logic [IDX_W-1:0] r_out_max_idx;

  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_take_max;
  logic             w_take_min;
  logic [WIDTH-1:0] w_next_max;
  logic [WIDTH-1:0] w_next_min;
  logic [IDX_W-1:0] w_next_idx;

  // Running extrema including the sample being offered; ties on max move the index to the later sample
  always_comb begin
    w_accept   = r_in_ready && i_in_valid;
    w_first    = (r_count == '0);
    w_last     = (r_count == LP_LAST_IDX);
    w_take_max = w_first || (i_in_data >= r_run_max);
    w_take_min = w_first || (i_in_data < r_run_min);
    w_next_max = w_take_max ? i_in_data : r_run_max;
    w_next_min = w_take_min ? i_in_data : r_run_min;
    w_next_idx = r_run_idx;
    if (w_first) begin
      w_next_idx = '0;
    end else if (w_take_max) begin
      w_next_idx = r_count;
    end
  end

  // Two-state controller: accumulate a frame, then hold the result until the consumer takes it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_ACCUM;
      r_count       <= '0;
      r_run_max     <= '0;
      r_run_min     <= '0;
      r_run_idx     <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_max     <= '0;
      r_out_min     <= '0;
      r_out_max_idx <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_run_max <= w_next_max;
            r_run_min <= w_next_min;
            r_run_idx <= w_next_idx;
            if (w_last) begin
              r_count       <= '0;
              r_out_max     <= w_next_max;
              r_out_min     <= w_next_min;
              r_out_max_idx <= w_next_idx;
              r_out_valid   <= 1'b1;
              r_in_ready    <= 1'b0;
              r_state       <= ST_HOLD;
            end else begin
              r_count <= r_count + IDX_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_ACCUM;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_count     <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_out_valid;
  assign o_out_max     = r_out_max;
  assign o_out_min     = r_out_min;
  assign o_out_max_idx = r_out_max_idx;

endmodule

// File: tb/tb_stream_max_min.sv
// tb/tb_stream_max_min.sv - directed self-checking bench for stream_max_min
module tb_stream_max_min;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_max;
  logic [7:0] out_min;
  logic [7:0] out_max_idx;

  int n_checks;
  int n_errors;

  stream_max_min #(
    .WIDTH    (8),
    .FRAME_LEN(3),
    .IDX_W    (8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_max    (out_max),
    .o_out_min    (out_min),
    .o_out_max_idx(out_max_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; offers one sample across the next posedge, returns at the following negedge
  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [7:0] emax, input logic [7:0] emin,
                              input logic [7:0] eidx);
    check_val({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check_val({tag, " max"}, 32'(out_max), 32'(emax));
    check_val({tag, " min"}, 32'(out_min), 32'(emin));
    check_val({tag, " idx"}, 32'(out_max_idx), 32'(eidx));
  endtask

  // Full frame with out_ready held high: result visible one edge after the last accept, gone the next
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] emax,
                           input logic [7:0] emin, input logic [7:0] eidx);
    out_ready = 1'b1;
    push(a);
    push(b);
    push(c);
    check_result(tag, emax, emin, eidx);
    @(negedge clk);
    check_val({tag, " after xfer out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, " after xfer in_ready"}, 32'(in_ready), 32'd1);
    check_val({tag, " after xfer max kept"}, 32'(out_max), 32'(emax));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;

    #2;
    check_val("reset out_valid", 32'(out_valid), 32'd0);
    check_val("reset out_max", 32'(out_max), 32'd0);
    check_val("reset out_min", 32'(out_min), 32'd0);
    check_val("reset out_max_idx", 32'(out_max_idx), 32'd0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post-reset in_ready", 32'(in_ready), 32'd1);
    check_val("post-reset out_valid", 32'(out_valid), 32'd0);

    run_frame("basic", 8'd3, 8'd9, 8'd5, 8'd9, 8'd3, 8'd1);
    run_frame("tie77", 8'd7, 8'd7, 8'd2, 8'd7, 8'd2, 8'd1);
    run_frame("extreme", 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd2);
    run_frame("all4", 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd2);

    // Backpressure: result must hold and HOLD-state offers must be ignored
    out_ready = 1'b0;
    push(8'd1);
    push(8'd2);
    push(8'd3);
    in_valid = 1'b1;
    in_data  = 8'd200;
    for (int i = 0; i < 5; i++) begin
      check_result("bp hold", 8'd3, 8'd1, 8'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp xfer out_valid", 32'(out_valid), 32'd0);
    check_val("bp xfer in_ready", 32'(in_ready), 32'd1);
    check_val("bp xfer max kept", 32'(out_max), 32'd3);
    run_frame("post-bp", 8'd5, 8'd6, 8'd4, 8'd6, 8'd4, 8'd1);

    // Input gaps leave state untouched
    push(8'd10);
    idle(3);
    check_val("gap no out_valid", 32'(out_valid), 32'd0);
    push(8'd20);
    idle(1);
    push(8'd15);
    check_result("gaps", 8'd20, 8'd10, 8'd1);
    @(negedge clk);

    // Asynchronous reset between edges discards the partial frame
    push(8'd50);
    push(8'd60);
    #2 rst_n = 1'b0;
    #1;
    check_val("async rst out_valid", 32'(out_valid), 32'd0);
    check_val("async rst out_max", 32'(out_max), 32'd0);
    check_val("async rst out_min", 32'(out_min), 32'd0);
    check_val("async rst out_max_idx", 32'(out_max_idx), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("post async rst in_ready", 32'(in_ready), 32'd1);
    run_frame("after rst", 8'd1, 8'd8, 8'd2, 8'd8, 8'd1, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
